raster_scan_ctrl: RTL and testbench
===================================

// Module: raster_scan_ctrl
// PURPOSE
//  Sequences the inside-triangle test stage. Accepts one triangle bounding box,
//  walks its pixels in raster order and issues each pixel to the barycentric /
//  inside-test pipeline using nd/rfd. Tracks in-flight pixels in a coordinate
//  FIFO, pairs each returned result with its (x,y), and emits only the pixels
//  that pass the test as fragments. Sits between triangle setup and fragment shading.
// PARAMETERS
//  COORD_W       10  pixel coordinate width (unsigned)
//  MAX_INFLIGHT   8  max pixels outstanding in the test pipeline; power of 2, >=2
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset: synchronous, active-high
//  tri_valid  in   1        bounding box present
//  tri_ready  out  1        block accepts a box (IDLE only)
//  bb_xmin    in   COORD_W  inclusive bounding-box limits, sampled on tri_valid&tri_ready
//  bb_xmax    in   COORD_W
//  bb_ymin    in   COORD_W
//  bb_ymax    in   COORD_W
//  px_nd      out  1        pixel issued to the test pipeline this cycle
//  px_x,px_y  out  COORD_W  issued pixel coordinates, valid with px_nd
//  px_rfd     in   1        test pipeline ready for data (its us_rfd)
//  res_ce     out  1        clock enable to the test pipeline (its ds_rfd)
//  res_rdy    in   1        test result valid
//  res_reject in   1        1 = pixel outside the triangle (coordinate <0 or >1)
//  frag_valid out  1        fragment output valid
//  frag_ready in   1        downstream accepts fragment
//  frag_x,frag_y out COORD_W fragment coordinates
//  busy       out  1        state != IDLE
//  tri_done   out  1        1-cycle pulse: all pixels of the box resolved
// BEHAVIOUR
//  Reset: state=IDLE; px_nd, frag_valid, tri_done, busy = 0; tri_ready = 1;
//   FIFO empty; inflight = 0; coordinate outputs = 0.
//  FSM IDLE -> SCAN -> DRAIN -> IDLE.
//   IDLE: tri_ready=1. On tri_valid, latch the box, cur=(xmin,ymin).
//    If xmin>xmax or ymin>ymax: degenerate; pulse tri_done next cycle,
//    stay IDLE, issue nothing.
//   SCAN: px_nd = px_rfd & res_ce & (inflight<MAX_INFLIGHT); combinational.
//    px_x/px_y = cur. On issue, push cur into the FIFO and advance:
//    x<xmax -> x+1; else x=xmin, y+1. Issuing (xmax,ymax) -> DRAIN.
//   DRAIN: no issue. When inflight==0 and no push/pop this cycle, pulse
//    tri_done for 1 cycle and go to IDLE.
//  Result path: res_ce = ~frag_valid | frag_ready. A result is consumed only on
//   res_rdy & res_ce; otherwise it is ignored (the pipeline is stalled).
//   On consume: pop the FIFO head. If ~res_reject, register head as frag_x/y
//   and set frag_valid next cycle. Rejected pixels produce no output.
//  frag_valid holds, with frag_x/y stable, until frag_ready; it clears the next
//   cycle unless a new accept loads it the same cycle (back-to-back supported).
//  inflight: +1 on issue, -1 on consume; both in one cycle -> unchanged.
//   Consume with an empty FIFO is a protocol error; it is ignored, not popped.
//  Throughput: 1 pixel/cycle in steady state with frag_ready=1. Issue-to-
//   fragment latency = pipeline latency + 1 (output register).
//  Coordinates do not wrap: bb_xmax/bb_ymax = 2^COORD_W-1 must be handled,
//   so compare before incrementing.
//  rst mid-triangle: drops all state immediately, with no tri_done. The test
//   pipeline shares rst, so no stale results return.
// TESTING
//  1. box (2,2)-(3,3), pipeline passes all, frag_ready=1 -> 4 fragments in
//     order (2,2),(3,2),(2,3),(3,3), then one tri_done pulse, tri_ready=1.
//  2. Same box, reject the 2nd and 4th results -> fragments (2,2),(2,3) only.
//     tri_done still fires after the 4th result.
//  3. box (5,5)-(4,5) -> no px_nd, tri_done exactly 1 cycle after accept.
//  4. box 1x16, MAX_INFLIGHT=8, frag_ready held 0 -> at most 8 px_nd
//     outstanding; res_ce=0 after first fragment; release -> all 16 in order.
//  5. box (1023,0)-(1023,1), COORD_W=10 -> pixels (1023,0),(1023,1); no wrap.
//  6. assert rst after 3 of 9 pixels issued -> next cycle IDLE, frag_valid=0,
//     inflight=0, no tri_done; new box then processes normally.

Source files
------------

// File: rtl/raster_scan_ctrl.sv
// Raster-order pixel sequencer for the inside-triangle test: walks a bounding box,
// pairs each returned test result with its (x,y) and emits the passing pixels as fragments.
module raster_scan_ctrl #(
   parameter int COORD_W      = 10,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tri_valid,
   output logic               tri_ready,
   input  logic [COORD_W-1:0] bb_xmin,
   input  logic [COORD_W-1:0] bb_xmax,
   input  logic [COORD_W-1:0] bb_ymin,
   input  logic [COORD_W-1:0] bb_ymax,
   output logic               px_nd,
   output logic [COORD_W-1:0] px_x,
   output logic [COORD_W-1:0] px_y,
   input  logic               px_rfd,
   output logic               res_ce,
   input  logic               res_rdy,
   input  logic               res_reject,
   output logic               frag_valid,
   input  logic               frag_ready,
   output logic [COORD_W-1:0] frag_x,
   output logic [COORD_W-1:0] frag_y,
   output logic               busy,
   output logic               tri_done
);

   localparam int PTR_W = $clog2(MAX_INFLIGHT);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t state, state_nxt;

   logic [COORD_W-1:0] xmin, xmax, ymax;
   logic [COORD_W-1:0] cur_x, cur_y;
   logic [COORD_W-1:0] fifo_x [MAX_INFLIGHT];
   logic [COORD_W-1:0] fifo_y [MAX_INFLIGHT];
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   inflight;
   logic               deg_done;
   logic               accept, degenerate, issue, consume, row_end, last_px;

   assign accept     = tri_valid & (state == IDLE);
   assign degenerate = (bb_xmin > bb_xmax) | (bb_ymin > bb_ymax);
   assign res_ce     = ~frag_valid | frag_ready;
   assign issue      = (state == SCAN) & px_rfd & res_ce & (inflight != CNT_FULL);
   // An empty FIFO means a stray result: never pop on it.
   assign consume    = res_rdy & res_ce & (inflight != '0);
   assign row_end    = (cur_x == xmax);
   assign last_px    = row_end & (cur_y == ymax);

   assign px_nd = issue;
   assign px_x  = cur_x;
   assign px_y  = cur_y;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tri_ready = 1'b0;
      busy      = 1'b1;
      tri_done  = deg_done;
      case (state)
         IDLE: begin
            tri_ready = 1'b1;
            busy      = 1'b0;
            if (accept && !degenerate) state_nxt = SCAN;
         end
         SCAN: begin
            if (issue && last_px) state_nxt = DRAIN;
         end
         DRAIN: begin
            // Nothing is issued here, so an empty count also means no pop this cycle.
            if (inflight == '0) begin
               tri_done  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Scan stage: box limits and raster cursor
   always_ff @(posedge clk) begin
      if (accept) begin
         xmin <= bb_xmin;
         xmax <= bb_xmax;
         ymax <= bb_ymax;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_x    <= '0;
         cur_y    <= '0;
         deg_done <= 1'b0;
      end else begin
         deg_done <= accept & degenerate;
         if (accept) begin
            cur_x <= bb_xmin;
            cur_y <= bb_ymin;
         end else if (issue && !last_px) begin
            // Compare before incrementing so limits at 2^COORD_W-1 never wrap.
            if (row_end) begin
               cur_x <= xmin;
               cur_y <= cur_y + COORD_W'(1);
            end else begin
               cur_x <= cur_x + COORD_W'(1);
            end
         end
      end
   end

   // In-flight stage: coordinate FIFO mirroring the test pipeline
   always_ff @(posedge clk) begin
      if (issue) begin
         fifo_x[wr_ptr] <= cur_x;
         fifo_y[wr_ptr] <= cur_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         inflight <= '0;
      end else begin
         if (issue)   wr_ptr <= wr_ptr + PTR_W'(1);
         if (consume) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({issue, consume})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   // Output stage: fragment register, reloadable in the cycle it is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         frag_valid <= 1'b0;
         frag_x     <= '0;
         frag_y     <= '0;
      end else if (consume && !res_reject) begin
         frag_valid <= 1'b1;
         frag_x     <= fifo_x[rd_ptr];
         frag_y     <= fifo_y[rd_ptr];
      end else if (frag_ready) begin
         frag_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Randomized bench for raster_scan_ctrl: a raster-order reference list plus a
// bench-side test pipeline, compared against the DUT every cycle.
module tb_raster_scan_ctrl;

   localparam int CW = 10;
   localparam int MI = 8;

   typedef struct {
      int x;
      int y;
      int k;
   } pix_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          tri_valid, tri_ready;
   logic [CW-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic          px_nd, px_rfd, res_ce, res_rdy, res_reject;
   logic [CW-1:0] px_x, px_y, frag_x, frag_y;
   logic          frag_valid, frag_ready, busy, tri_done;

   always #5 clk = ~clk;

   raster_scan_ctrl #(.COORD_W(CW), .MAX_INFLIGHT(MI)) dut (
      .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
      .bb_xmin(bb_xmin), .bb_xmax(bb_xmax), .bb_ymin(bb_ymin), .bb_ymax(bb_ymax),
      .px_nd(px_nd), .px_x(px_x), .px_y(px_y), .px_rfd(px_rfd), .res_ce(res_ce),
      .res_rdy(res_rdy), .res_reject(res_reject), .frag_valid(frag_valid),
      .frag_ready(frag_ready), .frag_x(frag_x), .frag_y(frag_y), .busy(busy),
      .tri_done(tri_done)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   pix_t        exp_pix[$], exp_frag[$], pipe[$], frag_log[$], issue_log[$];
   bit          run = 1'b0, active = 1'b0, out_valid = 1'b0;
   int          out_x = 0, out_y = 0, done_due = -1, n = 0;
   int          acc_count = 0, done_count = 0, accept_n = 0, done_n = 0;
   logic [63:0] mask = '0, mmask = '0;
   int          rfd_pct = 100, rdy_pct = 100, fr_pct = 100;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic chk_pix(input string tag, input int idx, input int x, input int y,
                          input bit from_frags);
      pix_t p;
      int   sz;
      sz = from_frags ? frag_log.size() : issue_log.size();
      if (idx >= sz) begin
         chk({tag, "_count"}, sz, idx + 1);
      end else begin
         p = from_frags ? frag_log[idx] : issue_log[idx];
         chk({tag, "_x"}, p.x, x);
         chk({tag, "_y"}, p.y, y);
      end
   endtask

   // Expected work for a box: every pixel in raster order; fragments are those whose mask bit is clear.
   task automatic build_box(input int x0, input int x1, input int y0, input int y1,
                            input logic [63:0] m);
      pix_t p;
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++) begin
            p.x = x;
            p.y = y;
            p.k = (y - y0) * (x1 - x0 + 1) + (x - x0);
            exp_pix.push_back(p);
            if (!m[p.k % 64]) exp_frag.push_back(p);
         end
   endtask

   // bench-side test pipeline and downstream: random handshakes
   initial begin : drive_rand
      px_rfd = 1'b0; res_rdy = 1'b0; res_reject = 1'b0; frag_ready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         px_rfd     = int'($urandom_range(99)) < rfd_pct;
         frag_ready = int'($urandom_range(99)) < fr_pct;
         if (pipe.size() > 0) begin
            res_rdy    = int'($urandom_range(99)) < rdy_pct;
            res_reject = mmask[pipe[0].k % 64];
         end else begin
            res_rdy    = 1'b0;
            res_reject = 1'b0;
         end
      end
   end

   initial begin : compare
      pix_t h, f, p;
      bit   exp_ce, exp_nd, cons, facc, acc;
      forever begin
         @(negedge clk);
         #3;
         n++;
         if (run) begin
            exp_ce = !out_valid || frag_ready;
            exp_nd = active && (exp_pix.size() > 0) && px_rfd && exp_ce && (pipe.size() < MI);
            chk("busy", int'(busy), int'(active));
            chk("tri_ready", int'(tri_ready), int'(!active));
            chk("tri_done", int'(tri_done), int'(n == done_due));
            chk("res_ce", int'(res_ce), int'(exp_ce));
            chk("px_nd", int'(px_nd), int'(exp_nd));
            chk("frag_valid", int'(frag_valid), int'(out_valid));
            if (out_valid) begin
               chk("frag_x_hold", int'(frag_x), out_x);
               chk("frag_y_hold", int'(frag_y), out_y);
            end
            if (exp_nd && px_nd) begin
               chk("px_x", int'(px_x), exp_pix[0].x);
               chk("px_y", int'(px_y), exp_pix[0].y);
            end
            if (tri_done) begin
               done_count++;
               done_n = n;
            end
            if (px_nd && !rst) begin
               p.x = int'(px_x); p.y = int'(px_y); p.k = 0;
               issue_log.push_back(p);
            end
            if (rst) begin
               exp_pix.delete(); exp_frag.delete(); pipe.delete();
               active = 1'b0; out_valid = 1'b0; done_due = -1;
            end else begin
               acc = tri_valid && !active;
               if (n == done_due) begin
                  active   = 1'b0;
                  done_due = -1;
               end
               facc = out_valid && frag_ready;
               cons = res_rdy && exp_ce && (pipe.size() > 0);
               if (facc) begin
                  chk("frag_expected", int'(exp_frag.size() > 0), 1);
                  if (exp_frag.size() > 0) begin
                     f = exp_frag.pop_front();
                     chk("frag_order_x", int'(frag_x), f.x);
                     chk("frag_order_y", int'(frag_y), f.y);
                  end
                  p.x = int'(frag_x); p.y = int'(frag_y); p.k = 0;
                  frag_log.push_back(p);
               end
               if (cons) begin
                  h = pipe.pop_front();
                  if (!mmask[h.k % 64]) begin
                     out_valid = 1'b1;
                     out_x     = h.x;
                     out_y     = h.y;
                  end else if (facc) begin
                     out_valid = 1'b0;
                  end
               end else if (facc) begin
                  out_valid = 1'b0;
               end
               if (exp_nd) begin
                  h = exp_pix.pop_front();
                  pipe.push_back(h);
               end
               if (acc) begin
                  acc_count++;
                  accept_n = n;
                  mmask    = mask;
                  if (bb_xmin > bb_xmax || bb_ymin > bb_ymax) begin
                     done_due = n + 1;
                  end else begin
                     active = 1'b1;
                     build_box(int'(bb_xmin), int'(bb_xmax), int'(bb_ymin), int'(bb_ymax), mask);
                  end
               end
               if (active && exp_pix.size() == 0 && pipe.size() == 0 && done_due < 0)
                  done_due = n + 1;
            end
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while ((active || done_due >= 0 || out_valid) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("box_timeout", int'(t < 3000), 1);
      chk("frags_left", exp_frag.size(), 0);
   endtask

   task automatic send_box(input int x0, input int x1, input int y0, input int y1,
                           input logic [63:0] m, input bit wait_done);
      int a0, t;
      @(negedge clk);
      bb_xmin = CW'(x0); bb_xmax = CW'(x1); bb_ymin = CW'(y0); bb_ymax = CW'(y1);
      mask = m;
      tri_valid = 1'b1;
      a0 = acc_count;
      t = 0;
      while (acc_count == a0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      tri_valid = 1'b0;
      chk("accept_timeout", int'(acc_count != a0), 1);
      if (wait_done) wait_idle();
   endtask

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int d0, t, x0, x1, y0, y1;
      rst = 1'b1; tri_valid = 1'b0;
      bb_xmin = '0; bb_xmax = '0; bb_ymin = '0; bb_ymax = '0;
      repeat (3) @(negedge clk);
      #4;
      chk("rst_tri_ready", int'(tri_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_px_nd", int'(px_nd), 0);
      chk("rst_frag_valid", int'(frag_valid), 0);
      chk("rst_tri_done", int'(tri_done), 0);
      chk("rst_px_x", int'(px_x), 0);
      chk("rst_frag_y", int'(frag_y), 0);
      @(negedge clk);
      rst = 1'b0;
      run = 1'b1;

      // all pass
      frag_log.delete(); d0 = done_count;
      send_box(2, 3, 2, 3, 64'h0, 1'b1);
      #4;
      chk_pix("t1_f0", 0, 2, 2, 1'b1); chk_pix("t1_f1", 1, 3, 2, 1'b1);
      chk_pix("t1_f2", 2, 2, 3, 1'b1); chk_pix("t1_f3", 3, 3, 3, 1'b1);
      chk("t1_nfrag", frag_log.size(), 4);
      chk("t1_done", done_count - d0, 1);
      chk("t1_tri_ready", int'(tri_ready), 1);

      // reject 2nd and 4th results
      frag_log.delete(); d0 = done_count;
      send_box(2, 3, 2, 3, 64'hA, 1'b1);
      chk_pix("t2_f0", 0, 2, 2, 1'b1); chk_pix("t2_f1", 1, 2, 3, 1'b1);
      chk("t2_nfrag", frag_log.size(), 2);
      chk("t2_done", done_count - d0, 1);

      // degenerate box
      issue_log.delete(); d0 = done_count;
      send_box(5, 4, 5, 5, 64'h0, 1'b1);
      chk("t3_issued", issue_log.size(), 0);
      chk("t3_done", done_count - d0, 1);
      chk("t3_done_delay", done_n - accept_n, 1);

      // in-flight limit with downstream stalled
      frag_log.delete(); issue_log.delete();
      rfd_pct = 100; rdy_pct = 0; fr_pct = 0;
      send_box(0, 15, 7, 7, 64'h0, 1'b0);
      repeat (14) @(negedge clk);
      #4;
      chk("t4_issued_cap", issue_log.size(), MI);
      chk("t4_px_nd_cap", int'(px_nd), 0);
      rdy_pct = 100;
      repeat (4) @(negedge clk);
      #4;
      chk("t4_res_ce", int'(res_ce), 0);
      chk("t4_frag_valid", int'(frag_valid), 1);
      chk("t4_frag_x", int'(frag_x), 0);
      chk("t4_issued_hold", issue_log.size(), MI);
      fr_pct = 100;
      wait_idle();
      chk("t4_nfrag", frag_log.size(), 16);
      for (int i = 0; i < 16; i++) chk_pix($sformatf("t4_f%0d", i), i, i, 7, 1'b1);

      // right edge of the coordinate range
      frag_log.delete(); issue_log.delete();
      send_box(1023, 1023, 0, 1, 64'h0, 1'b1);
      chk_pix("t5_i0", 0, 1023, 0, 1'b0); chk_pix("t5_i1", 1, 1023, 1, 1'b0);
      chk("t5_issued", issue_log.size(), 2);
      chk_pix("t5_f1", 1, 1023, 1, 1'b1);

      // reset mid-triangle
      issue_log.delete(); d0 = done_count;
      send_box(10, 12, 20, 22, 64'h0, 1'b0);
      t = 0;
      while (issue_log.size() < 3 && t < 200) begin
         @(negedge clk);
         t++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #4;
      chk("t6_issued", issue_log.size(), 3);
      chk("t6_busy", int'(busy), 0);
      chk("t6_frag_valid", int'(frag_valid), 0);
      chk("t6_tri_ready", int'(tri_ready), 1);
      repeat (3) @(negedge clk);
      chk("t6_no_done", done_count - d0, 0);
      rfd_pct = 70; rdy_pct = 60; fr_pct = 80;
      send_box(10, 12, 20, 22, {$urandom, $urandom}, 1'b1);
      chk("t6_after_done", done_count - d0, 1);

      // random boxes, handshake rates and reject masks
      for (int b = 0; b < 30; b++) begin
         x0 = int'($urandom_range(1023));
         y0 = int'($urandom_range(1023));
         x1 = x0 + int'($urandom_range(5));
         y1 = y0 + int'($urandom_range(4));
         if (x1 > 1023) x1 = 1023;
         if (y1 > 1023) y1 = 1023;
         if (b % 7 == 3) begin
            x0 = 500;
            x1 = 499;
         end
         rfd_pct = int'($urandom_range(30, 100));
         rdy_pct = int'($urandom_range(30, 100));
         fr_pct  = int'($urandom_range(30, 100));
         d0 = done_count;
         send_box(x0, x1, y0, y1, {$urandom, $urandom}, 1'b1);
         chk("rand_done", done_count - d0, 1);
      end

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
